// File: rtl/ariane_sram_pkg.sv
// Shared helpers for the banked SRAM: parameter formulas and the round-robin pick.
package ariane_sram_pkg;

    localparam int unsigned MAX_PORTS   = 32;
    localparam int unsigned MAX_PORTS_W = 5;

    function automatic int unsigned calc_bw(input int unsigned data_width);
        return (data_width + 32'd7) / 32'd8;
    endfunction

    function automatic int unsigned calc_bank_aw(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    // First set bit of req at or after ptr, wrapping within n ports.
    function automatic int unsigned rr_arb(input logic [MAX_PORTS-1:0] req,
                                           input int unsigned        ptr,
                                           input int unsigned        n);
        int unsigned idx;
        int unsigned win;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < n && !found) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_PORTS_W-1:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/ariane_sram_banked_if.sv
// Request/response bundle between SRAM masters and the banked SRAM.
interface ariane_sram_banked_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned AW         = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BW         = 8
);
    logic [NUM_PORTS-1:0]                 req_i;
    logic [NUM_PORTS-1:0]                 we_i;
    logic [NUM_PORTS-1:0][AW-1:0]         addr_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0][BW-1:0]         be_i;
    logic [NUM_PORTS-1:0]                 gnt_o;
    logic [NUM_PORTS-1:0]                 rvalid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;

    modport master (output req_i, we_i, addr_i, wdata_i, be_i,
                    input  gnt_o, rvalid_o, rdata_o);
    modport slave  (input  req_i, we_i, addr_i, wdata_i, be_i,
                    output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/ariane_sram_bank.sv
// Single-port byte-enabled bank with synchronous read and optional output register.
module ariane_sram_bank
    import ariane_sram_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned NUM_WORDS  = 512,
    parameter  int unsigned OUT_REGS   = 0,
    localparam int unsigned BW         = calc_bw(DATA_WIDTH),
    localparam int unsigned RAW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk_i,
    input  logic                  req,
    input  logic                  we,
    input  logic [RAW-1:0]        row,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BW-1:0]         be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] rd_q;

    // Expand byte enables to a bit mask; the top lane may be partial.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
        assign bit_mask[i] = be[i/8];
    end

    always_ff @(posedge clk_i) begin
        if (req) begin
            if (we) mem[row] <= (mem[row] & ~bit_mask) | (wdata & bit_mask);
            else    rd_q     <= mem[row];
        end
    end

    if (OUT_REGS != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] out_q;
        always_ff @(posedge clk_i) out_q <= rd_q;
        assign rdata = out_q;
    end else begin : g_noreg
        assign rdata = rd_q;
    end

endmodule

// File: rtl/ariane_sram_banked.sv
// Multi-port word-interleaved SRAM: per-bank round-robin arbitration, crossbar, read return tracking.
module ariane_sram_banked
    import ariane_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned OUT_REGS   = 0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ariane_sram_banked_if.slave bus
);

    localparam int unsigned AW         = $clog2(NUM_WORDS);
    localparam int unsigned BW         = calc_bw(DATA_WIDTH);
    localparam int unsigned BANK_AW    = calc_bank_aw(NUM_BANKS);
    localparam int unsigned BANK_WORDS = NUM_WORDS / NUM_BANKS;
    localparam int unsigned ROW_W      = AW - BANK_AW;
    localparam int unsigned BSEL_W     = (BANK_AW > 0) ? BANK_AW : 1;
    localparam int unsigned PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned DEPTH      = 1 + OUT_REGS;

    logic [NUM_PORTS-1:0][BSEL_W-1:0]            port_bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]             port_row;
    logic [NUM_PORTS-1:0]                        gnt_c;
    logic [NUM_BANKS-1:0]                        bank_gnt;
    logic [NUM_BANKS-1:0][PW-1:0]                bank_win;
    logic [DATA_WIDTH-1:0]                       bank_rdata [NUM_BANKS];
    logic [NUM_PORTS-1:0][DEPTH-1:0]             vld_q;
    logic [NUM_PORTS-1:0][DEPTH-1:0][BSEL_W-1:0] src_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        hold_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        rdata_c;

    // Low address bits pick the bank, the rest the row inside it.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        if (BANK_AW > 0) begin : g_multi
            assign port_bank[p] = bus.addr_i[p][BSEL_W-1:0];
            assign port_row[p]  = bus.addr_i[p][AW-1:BSEL_W];
        end else begin : g_single
            assign port_bank[p] = '0;
            assign port_row[p]  = bus.addr_i[p];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [MAX_PORTS-1:0] breq;
        logic                 gnt_b;
        logic [PW-1:0]        win_b;
        logic [PW-1:0]        rr_q;

        always_comb begin
            breq = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                breq[p] = bus.req_i[p] && (port_bank[p] == BSEL_W'(b));
            end
            gnt_b = !rst_i && (|breq);
            win_b = PW'(rr_arb(breq, 32'(rr_q), NUM_PORTS));
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_q <= '0;
            end else if (gnt_b) begin
                rr_q <= (32'(win_b) + 32'd1 >= NUM_PORTS) ? '0 : win_b + PW'(1);
            end
        end

        assign bank_gnt[b] = gnt_b;
        assign bank_win[b] = win_b;

        ariane_sram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WORDS  (BANK_WORDS),
            .OUT_REGS   (OUT_REGS)
        ) u_bank (
            .clk_i (clk_i),
            .req   (gnt_b),
            .we    (bus.we_i[win_b]),
            .row   (port_row[win_b]),
            .wdata (bus.wdata_i[win_b]),
            .be    (bus.be_i[win_b]),
            .rdata (bank_rdata[b])
        );
    end

    // A port is granted when its bank's arbiter picked it.
    always_comb begin
        gnt_c = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            gnt_c[p] = bank_gnt[port_bank[p]] && (bank_win[port_bank[p]] == PW'(p));
        end
    end

    // Read tracking: valid bit plus source bank, aligned with the bank read latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            src_q  <= '0;
            hold_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                vld_q[p][0] <= gnt_c[p] && !bus.we_i[p];
                src_q[p][0] <= port_bank[p];
                for (int unsigned s = 1; s < DEPTH; s++) begin
                    vld_q[p][s] <= vld_q[p][s-1];
                    src_q[p][s] <= src_q[p][s-1];
                end
                if (vld_q[p][DEPTH-1]) hold_q[p] <= rdata_c[p];
            end
        end
    end

    always_comb begin
        bus.gnt_o    = gnt_c;
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        rdata_c      = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rdata_c[p]      = bank_rdata[src_q[p][DEPTH-1]];
            bus.rvalid_o[p] = vld_q[p][DEPTH-1];
            bus.rdata_o[p]  = vld_q[p][DEPTH-1] ? rdata_c[p] : hold_q[p];
        end
    end

endmodule

// File: tb/tb_ariane_sram_banked.sv
// Bench for ariane_sram_banked: a 64-bit zero-latency-register instance and a 36-bit OUT_REGS instance.
module tb_ariane_sram_banked;

    typedef struct {
        int          dut;
        int          port;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    exp_t        sb[$];
    logic [63:0] mdl[int];

    ariane_sram_banked_if #(.NUM_PORTS(2), .AW(10), .DATA_WIDTH(64), .BW(8)) ia ();
    ariane_sram_banked_if #(.NUM_PORTS(2), .AW(6),  .DATA_WIDTH(36), .BW(5)) ib ();

    ariane_sram_banked #(.DATA_WIDTH(64), .NUM_WORDS(1024), .NUM_BANKS(2), .NUM_PORTS(2), .OUT_REGS(0))
        dut_a (.clk_i(clk), .rst_i(rst_a), .bus(ia));
    ariane_sram_banked #(.DATA_WIDTH(36), .NUM_WORDS(64), .NUM_BANKS(2), .NUM_PORTS(2), .OUT_REGS(1))
        dut_b (.clk_i(clk), .rst_i(rst_b), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Uniform views of both instances, indexed by dut number.
    logic [1:0]  rst_v;
    logic [1:0]  rq[2], gn[2], wev[2], rv[2];
    logic [9:0]  ad[2][2];
    logic [63:0] wdv[2][2], rd[2][2];
    logic [7:0]  bev[2][2];

    always_comb begin
        rst_v = {rst_b, rst_a};
        rq[0] = ia.req_i; gn[0] = ia.gnt_o; wev[0] = ia.we_i; rv[0] = ia.rvalid_o;
        rq[1] = ib.req_i; gn[1] = ib.gnt_o; wev[1] = ib.we_i; rv[1] = ib.rvalid_o;
        for (int p = 0; p < 2; p++) begin
            ad[0][p]  = ia.addr_i[p];
            wdv[0][p] = ia.wdata_i[p];
            bev[0][p] = ia.be_i[p];
            rd[0][p]  = ia.rdata_o[p];
            ad[1][p]  = 10'(ib.addr_i[p]);
            wdv[1][p] = 64'(ib.wdata_i[p]);
            bev[1][p] = 8'(ib.be_i[p]);
            rd[1][p]  = 64'(ib.rdata_o[p]);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] be_mask(input logic [7:0] be, input int dw);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 64; k++) if (k < dw && be[k/8]) m[k] = 1'b1;
        return m;
    endfunction

    // Scoreboard: match returns, flag missing returns, then record this cycle's grants.
    always @(negedge clk) begin
        int          idx;
        int          key;
        logic [63:0] m;
        logic [63:0] old;
        for (int d = 0; d < 2; d++) begin
            if (rst_v[d]) begin
                for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == d) sb.delete(i);
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (rv[d][p]) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++)
                            if (idx < 0 && sb[i].dut == d && sb[i].port == p) idx = i;
                        if (idx < 0) begin
                            check($sformatf("rvalid_unexpected d%0d p%0d", d, p), 64'd1, 64'd0);
                        end else begin
                            check($sformatf("rdata d%0d p%0d", d, p), rd[d][p], sb[idx].data);
                            check($sformatf("rvalid_cycle d%0d p%0d", d, p), 64'(cyc), 64'(sb[idx].due));
                            sb.delete(idx);
                        end
                    end
                end
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].dut == d && sb[i].due < cyc) begin
                        check($sformatf("rvalid_missing d%0d p%0d", d, sb[i].port), 64'd0, 64'd1);
                        sb.delete(i);
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (rq[d][p] && gn[d][p]) begin
                        key = d * 4096 + int'(ad[d][p]);
                        if (wev[d][p]) begin
                            m   = be_mask(bev[d][p], (d == 0) ? 64 : 36);
                            old = mdl.exists(key) ? mdl[key] : 64'd0;
                            mdl[key] = (old & ~m) | (wdv[d][p] & m);
                        end else begin
                            sb.push_back('{dut: d, port: p,
                                           data: mdl.exists(key) ? mdl[key] : 64'd0,
                                           due: cyc + ((d == 0) ? 1 : 2)});
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int d, input int p, input logic req, input logic we,
                            input logic [9:0] addr, input logic [63:0] wd, input logic [7:0] be);
        if (d == 0) begin
            ia.req_i[p] = req; ia.we_i[p] = we; ia.addr_i[p] = addr;
            ia.wdata_i[p] = wd; ia.be_i[p] = be;
        end else begin
            ib.req_i[p] = req; ib.we_i[p] = we; ib.addr_i[p] = addr[5:0];
            ib.wdata_i[p] = wd[35:0]; ib.be_i[p] = be[4:0];
        end
    endtask

    // Single-port access that holds its request until granted.
    task automatic access(input int d, input int p, input logic we, input logic [9:0] addr,
                          input logic [63:0] wd, input logic [7:0] be);
        int          n;
        logic [1:0]  g;
        n = 0;
        set_port(d, p, 1'b1, we, addr, wd, be);
        @(negedge clk);
        forever begin
            g = (d == 0) ? ia.gnt_o : ib.gnt_o;
            if (g[p]) break;
            n++;
            if (n > 20) begin
                check("gnt_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        step();
        set_port(d, p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] expg;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int p = 0; p < 2; p++) begin
            set_port(0, p, 1'b1, 1'b1, 10'd0, 64'd0, 8'h00);
            set_port(1, p, 1'b0, 1'b0, 10'd0, 64'd0, 8'h00);
        end

        repeat (3) step();
        @(negedge clk);
        check("gnt_in_reset", 64'(ia.gnt_o), 64'd0);
        step();
        rst_a = 1'b0;

        // Both ports contend for bank 0 with no-op writes; port 0 wins first.
        @(negedge clk);
        check("rvalid_after_reset", 64'(ia.rvalid_o), 64'd0);
        check("rdata0_after_reset", ia.rdata_o[0], 64'd0);
        check("rdata1_after_reset", ia.rdata_o[1], 64'd0);
        check("first_gnt", 64'(ia.gnt_o), 64'b01);
        step();
        @(negedge clk);
        check("second_gnt", 64'(ia.gnt_o), 64'b10);
        step();
        set_port(0, 0, 1'b0, 1'b0, '0, '0, '0);
        set_port(0, 1, 1'b0, 1'b0, '0, '0, '0);

        // Partial write merges into a full write.
        access(0, 0, 1'b1, 10'd4, 64'h1122334455667788, 8'hFF);
        access(0, 0, 1'b1, 10'd4, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        access(0, 0, 1'b0, 10'd4, 64'd0, 8'h00);
        repeat (3) step();
        check("merge_hold", ia.rdata_o[0], 64'h11223344AAAAAAAA);

        // Different banks are granted together.
        access(0, 0, 1'b1, 10'd2, 64'h0202020202020202, 8'hFF);
        access(0, 1, 1'b1, 10'd3, 64'h0303030303030303, 8'hFF);
        set_port(0, 0, 1'b1, 1'b0, 10'd2, '0, '0);
        set_port(0, 1, 1'b1, 1'b0, 10'd3, '0, '0);
        @(negedge clk);
        check("diff_bank_gnt", 64'(ia.gnt_o), 64'b11);
        step();

        // Back-to-back reads on both ports without conflicts.
        for (int i = 0; i < 4; i++) begin
            set_port(0, 0, 1'b1, 1'b0, (i % 2 == 0) ? 10'd4 : 10'd2, '0, '0);
            set_port(0, 1, 1'b1, 1'b0, 10'd3, '0, '0);
            @(negedge clk);
            check("pipe_gnt", 64'(ia.gnt_o), 64'b11);
            step();
        end
        set_port(0, 0, 1'b0, 1'b0, '0, '0, '0);
        set_port(0, 1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step();

        // Last bank-0 grant to port 1 leaves the pointer at 0; then both hammer addr 6.
        access(0, 1, 1'b1, 10'd6, 64'h6666666666666666, 8'hFF);
        set_port(0, 0, 1'b1, 1'b0, 10'd6, '0, '0);
        set_port(0, 1, 1'b1, 1'b0, 10'd6, '0, '0);
        expg = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_alternate", 64'(ia.gnt_o), 64'(expg));
            expg = {expg[0], expg[1]};
            step();
        end
        set_port(0, 0, 1'b0, 1'b0, '0, '0, '0);
        set_port(0, 1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step();

        // 36-bit instance with output register.
        rst_b = 1'b0;
        @(negedge clk);
        check("b_rvalid_after_reset", 64'(ib.rvalid_o), 64'd0);
        check("b_rdata_after_reset", 64'(ib.rdata_o[0]), 64'd0);
        step();
        access(1, 0, 1'b1, 10'd1, 64'd0, 8'h1F);
        access(1, 0, 1'b1, 10'd1, 64'hF_FFFF_FFFF, 8'h10);
        access(1, 0, 1'b0, 10'd1, 64'd0, 8'h00);
        repeat (4) step();
        check("b_top_lane", 64'(ib.rdata_o[0]), 64'hF_0000_0000);

        // Reset lands while a read is in flight: its return must vanish.
        access(1, 1, 1'b0, 10'd1, 64'd0, 8'h00);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_no_rvalid_after_rst", 64'(ib.rvalid_o), 64'd0);
            check("b_rdata_zero_after_rst", 64'(ib.rdata_o[0]), 64'd0);
            step();
        end

        repeat (3) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ariane_sram_banked.md
# ariane_sram_banked

Multi-port, banked SRAM for the Ariane memory subsystem. It is the parametrised successor of the single-port byte-enable SRAM wrapper. NUM_PORTS requesters share NUM_BANKS word-interleaved single-port banks, with per-bank round-robin arbitration, a req/gnt handshake and a configurable read latency signalled by rvalid. It sits between cache/scratchpad masters and inferred FPGA/ASIC RAM.

## Interface
- DATA_WIDTH, 64: word width in bits; need not be a multiple of 8 (the top byte lane is partial).
- NUM_WORDS, 1024: total words; must be a multiple of NUM_BANKS.
- NUM_BANKS, 2: bank count; power of two, ≥1.
- NUM_PORTS, 2: requester count, ≥1.
- OUT_REGS, 0: 1 adds an output register stage, so read latency is 2 instead of 1.
- Derived: AW = $clog2(NUM_WORDS), BW = (DATA_WIDTH+7)/8, BANK_AW = $clog2(NUM_BANKS).
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  [NUM_PORTS]  per-port request.
- we_i  in  [NUM_PORTS]  1 = write, 0 = read.
- addr_i  in  [NUM_PORTS][AW]  word address.
- wdata_i  in  [NUM_PORTS][DATA_WIDTH]  write data.
- be_i  in  [NUM_PORTS][BW]  byte enables; be bit k covers data bits 8k..8k+7.
- gnt_o  out  [NUM_PORTS]  combinational grant; the access is accepted in a cycle where req_i & gnt_o.
- rvalid_o  out  [NUM_PORTS]  read data valid.
- rdata_o  out  [NUM_PORTS][DATA_WIDTH]  read data.

## Operation
- Bank select is addr_i[BANK_AW-1:0]. The row within the bank is addr_i[AW-1:BANK_AW].
- Each bank serves at most one access per cycle.
- Arbitration per bank:
  - Round-robin among ports requesting that bank.
  - Priority pointer rr_q[bank] (reset 0). The winner is the first requesting port at or after rr_q, wrapping around.
  - On a grant, rr_q becomes winner+1 mod NUM_PORTS. It is unchanged if there is no grant.
- Ports addressing different banks are all granted in the same cycle.
- A denied port keeps req_i and its payload stable until granted. No timeout.
- Writes: only bytes with be=1 are updated; other bytes are retained. be=0 on all lanes is a granted no-op. Writes never produce rvalid.
- Reads: return the full word. rvalid_o[p] pulses for exactly one cycle per granted read, in grant order.
- rdata_o[p] holds its last value between rvalids.
- Read-after-write to the same address: a read granted in a later cycle returns the new data. Two same-cycle accesses to one bank cannot occur because arbitration serialises them.
- Bank contents are not reset and are X until written.
- While rst_i=1: gnt_o=0 and no memory update.

## Timing
- gnt_o depends combinationally on req_i, addr_i and rr_q. There is no path from rdata_o.
- Read latency, counted from the grant cycle N:
  - OUT_REGS=0: rvalid_o and rdata_o in cycle N+1.
  - OUT_REGS=1: rvalid_o and rdata_o in cycle N+2.
- Fully pipelined: one read per port per cycle is sustainable with no bank conflicts.
- Reset values: rvalid_o=0, rdata_o=0, rr_q=0, and the pipeline valid bits are cleared.
- Reset asserted mid-read: pending rvalids are dropped and never emitted.
- A write at cycle N is visible to a read granted at N+1 or later.

## Structure
- Package ariane_sram_pkg holds:
  - the rr_arb helper function (first-set-at-or-after-pointer);
  - localparam formulas for BW and BANK_AW.
- Sub-module ariane_sram_bank: single-port, byte-enabled, synchronous-read bank with optional output register. Parameters DATA_WIDTH, NUM_WORDS/NUM_BANKS, OUT_REGS. It is instantiated NUM_BANKS times.
- The top level contains:
  - per-bank arbiters and rr_q registers;
  - a bank-to-port crossbar;
  - per-port valid shift registers of depth 1+OUT_REGS, recording the source bank for returning read data.

## Test plan
- Reset with all req_i=1 → gnt_o=0. Then release reset → rvalid_o=0, rdata_o=0; the first grants go to port 0 per bank.
- Port 0 writes 0x1122334455667788 to addr 4 with be=0xFF, then writes 0xAAAAAAAAAAAAAAAA with be=0x0F, then reads → rdata_o[0]=0x11223344AAAAAAAA. rvalid arrives 1 cycle after grant with OUT_REGS=0 and 2 cycles after with OUT_REGS=1.
- Ports 0 and 1 read addr 2 and 3 (different banks, NUM_BANKS=2) in the same cycle → both gnt_o=1 and both rvalid in the next cycle.
- Ports 0 and 1 both continuously request addr 6 (same bank) for 4 cycles → grants alternate 0,1,0,1 and rr_q wraps.
- Read data returns while reset is asserted at latency-1 → no rvalid_o is emitted after reset; the outputs are 0.
- DATA_WIDTH=36 (BW=5): write 0xFFFFFFFFF with be=0x10 over 0 → read returns 0xF00000000.
